perf_counter_bank: RTL and testbench

Parametrised bank of event counters for processor performance monitoring. It is the successor to the fixed per-instruction counter, with a configurable channel count, counter width and per-cycle increment width (for multi-issue events). It adds wrap or saturate overflow modes, sticky overflow flags, freeze, synchronous clear, a snapshot shadow bank and an addressed read port with one-cycle latency. It sits beside the pipeline: decode/branch logic drives the per-channel increments, and a debug/host interface reads results.

---
 rtl/perf_counter_bank.sv | 149 ++++++++++++++
 tb/tb_perf_counter_bank.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// perf_counter_bank
// -----------------
// Bank of NUM_CH event counters for performance monitoring. Each channel adds
// a small per-cycle increment (0..2^INC_W-1) to a CNT_W-bit counter, either
// wrapping or saturating on overflow, with a sticky overflow flag per channel.
// A shadow bank captures all live counters on snap, and an addressed read
// port returns a live or shadow value with a fixed one-cycle latency.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   global_en  counting enable
//   freeze     holds all counters (reads, snapshot and clear still work)
//   inc        per-channel increments, channel i at [i*INC_W +: INC_W]
//   clear      synchronous clear of counters and overflow flags
//   snap       copy live counters into the shadow bank
//   rd_en      read request; rd_addr / rd_src sampled when high
//   rd_addr    channel to read
//   rd_src     0 = live counter, 1 = shadow copy
//   rd_data    read result (holds its last value when no read is issued)
//   rd_valid   one-cycle pulse, one cycle after rd_en
//   rd_err     address out of range, qualified by rd_valid
//   ovf        sticky per-channel overflow flags
//   ovf_any    OR of ovf
module perf_counter_bank #(
    parameter int NUM_CH   = 18,
    parameter int CNT_W    = 32,
    parameter int INC_W    = 2,
    parameter int SATURATE = 0,
    parameter int AW       = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    global_en,
    input  logic                    freeze,
    input  logic [NUM_CH*INC_W-1:0] inc,
    input  logic                    clear,
    input  logic                    snap,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    input  logic                    rd_src,
    output logic [CNT_W-1:0]        rd_data,
    output logic                    rd_valid,
    output logic                    rd_err,
    output logic [NUM_CH-1:0]       ovf,
    output logic                    ovf_any
);

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_r;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_nxt_s;
    logic [NUM_CH-1:0][CNT_W-1:0] shadow_r;
    logic [NUM_CH-1:0]            ovf_r;
    logic [NUM_CH-1:0]            ovf_nxt_s;
    logic                         count_en_s;
    logic [CNT_W-1:0]             rd_sel_s;
    logic                         rd_oor_s;
    logic [CNT_W-1:0]             rd_data_r;
    logic                         rd_valid_r;
    logic                         rd_err_r;

    assign count_en_s = global_en & ~freeze;

    // Next counter and overflow state: clear beats counting, carry out of the
    // CNT_W+1-bit sum marks an overflow.
    always_comb begin
        cnt_nxt_s = cnt_r;
        ovf_nxt_s = ovf_r;
        for (int i = 0; i < NUM_CH; i++) begin
            logic [CNT_W:0] sum_s;
            sum_s = {1'b0, cnt_r[i]} + {{(CNT_W + 1 - INC_W){1'b0}}, inc[i*INC_W +: INC_W]};
            if (clear) begin
                cnt_nxt_s[i] = '0;
                ovf_nxt_s[i] = 1'b0;
            end else if (count_en_s) begin
                if (sum_s[CNT_W]) begin
                    ovf_nxt_s[i] = 1'b1;
                    // A saturated counter re-saturates on every further
                    // nonzero increment, so the flag never toggles back.
                    if (SATURATE != 0) begin
                        cnt_nxt_s[i] = '1;
                    end else begin
                        cnt_nxt_s[i] = sum_s[CNT_W-1:0];
                    end
                end else begin
                    cnt_nxt_s[i] = sum_s[CNT_W-1:0];
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // Read-port select: one-hot OR across channels, so an out-of-range
    // address naturally yields zero.
    always_comb begin
        rd_sel_s = '0;
        rd_oor_s = (int'(rd_addr) >= NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            rd_sel_s = rd_sel_s |
                       ({CNT_W{int'(rd_addr) == i}} & (rd_src ? shadow_r[i] : cnt_r[i]));
        end
    end

    // Live counter and sticky overflow registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
            ovf_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
            ovf_r <= ovf_nxt_s;
        end
    end

    // Shadow bank captures pre-update live values; clear does not touch it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_r <= '0;
        end else if (snap) begin
            shadow_r <= cnt_r;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Read response registers: one-cycle latency, data held between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
            rd_err_r   <= 1'b0;
        end else begin
            rd_valid_r <= rd_en;
            rd_err_r   <= rd_en & rd_oor_s;
            if (rd_en) begin
                rd_data_r <= rd_oor_s ? '0 : rd_sel_s;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign rd_err   = rd_err_r;
    assign ovf      = ovf_r;
    assign ovf_any  = |ovf_r;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Testbench for perf_counter_bank: a wrapping and a saturating instance share
// the same stimulus and are compared every cycle against a reference model.
module tb_perf_counter_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       global_en;
    logic       freeze;
    logic [7:0] inc;
    logic       clear;
    logic       snap;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic       rd_src;

    logic [7:0] w_rd_data,  s_rd_data;
    logic       w_rd_valid, s_rd_valid;
    logic       w_rd_err,   s_rd_err;
    logic [3:0] w_ovf,      s_ovf;
    logic       w_ovf_any,  s_ovf_any;

    int checks = 0;
    int errors = 0;

    // Reference model, index 0 = wrapping instance, 1 = saturating instance.
    int m_cnt[2][4];
    int m_sh[2][4];
    int m_ovf[2][4];
    int m_rdata[2];
    int m_valid;
    int m_err;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .INC_W(2), .SATURATE(0), .AW(3)) dut_wrap (
        .clk(clk), .reset(reset), .global_en(global_en), .freeze(freeze), .inc(inc),
        .clear(clear), .snap(snap), .rd_en(rd_en), .rd_addr(rd_addr), .rd_src(rd_src),
        .rd_data(w_rd_data), .rd_valid(w_rd_valid), .rd_err(w_rd_err),
        .ovf(w_ovf), .ovf_any(w_ovf_any));

    perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .INC_W(2), .SATURATE(1), .AW(3)) dut_sat (
        .clk(clk), .reset(reset), .global_en(global_en), .freeze(freeze), .inc(inc),
        .clear(clear), .snap(snap), .rd_en(rd_en), .rd_addr(rd_addr), .rd_src(rd_src),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .rd_err(s_rd_err),
        .ovf(s_ovf), .ovf_any(s_ovf_any));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                m_cnt[d][c] = 0;
                m_sh[d][c]  = 0;
                m_ovf[d][c] = 0;
            end
            m_rdata[d] = 0;
        end
        m_valid = 0;
        m_err   = 0;
    endtask

    // Apply one clock edge to the model using the currently driven inputs.
    task automatic model_edge();
        int incv, t;
        m_valid = rd_en ? 1 : 0;
        m_err   = (rd_en && rd_addr >= 3'd4) ? 1 : 0;
        for (int d = 0; d < 2; d++) begin
            if (rd_en) begin
                if (rd_addr >= 3'd4) m_rdata[d] = 0;
                else if (rd_src)     m_rdata[d] = m_sh[d][rd_addr];
                else                 m_rdata[d] = m_cnt[d][rd_addr];
            end
            if (snap) begin
                for (int c = 0; c < 4; c++) m_sh[d][c] = m_cnt[d][c];
            end
            for (int c = 0; c < 4; c++) begin
                incv = int'((inc >> (2 * c)) & 8'd3);
                if (clear) begin
                    m_cnt[d][c] = 0;
                    m_ovf[d][c] = 0;
                end else if (global_en && !freeze) begin
                    t = m_cnt[d][c] + incv;
                    if (t > 255) begin
                        m_ovf[d][c] = 1;
                        m_cnt[d][c] = (d == 1) ? 255 : t - 256;
                    end else begin
                        m_cnt[d][c] = t;
                    end
                end
            end
        end
    endtask

    function automatic logic [3:0] ovf_vec(input int d);
        logic [3:0] v;
        v = 4'd0;
        for (int c = 0; c < 4; c++) v[c] = (m_ovf[d][c] != 0);
        return v;
    endfunction

    task automatic check_all();
        chk("w_valid", w_rd_valid, 64'(m_valid));
        chk("s_valid", s_rd_valid, 64'(m_valid));
        chk("w_err",   w_rd_err,   64'(m_err));
        chk("s_err",   s_rd_err,   64'(m_err));
        chk("w_data",  w_rd_data,  64'(m_rdata[0]));
        chk("s_data",  s_rd_data,  64'(m_rdata[1]));
        chk("w_ovf",   w_ovf,      64'(ovf_vec(0)));
        chk("s_ovf",   s_ovf,      64'(ovf_vec(1)));
        chk("w_ovf_any", w_ovf_any, 64'(ovf_vec(0) != 4'd0));
        chk("s_ovf_any", s_ovf_any, 64'(ovf_vec(1) != 4'd0));
    endtask

    task automatic idle();
        global_en = 1'b1;
        freeze    = 1'b0;
        inc       = 8'd0;
        clear     = 1'b0;
        snap      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = 3'd0;
        rd_src    = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Issue one read and compare against literal expected values.
    task automatic read_expect(input string tag, input logic [2:0] addr, input logic src,
                               input logic [7:0] exp_w, input logic [7:0] exp_s,
                               input logic exp_err);
        rd_en   = 1'b1;
        rd_addr = addr;
        rd_src  = src;
        cycle();
        chk({tag, "_w"},     w_rd_data,  64'(exp_w));
        chk({tag, "_s"},     s_rd_data,  64'(exp_s));
        chk({tag, "_valid"}, w_rd_valid, 64'd1);
        chk({tag, "_err"},   w_rd_err,   64'(exp_err));
        rd_en = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        model_reset();
        #2;
        check_all();
        chk("reset_data", w_rd_data, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic count: ch0 +1 and ch1 +3 for ten cycles.
        inc = 8'b0000_1101;
        cycles(10);
        inc = 8'd0;
        cycle();
        chk("valid_idle", w_rd_valid, 64'd0);
        read_expect("basic_ch0", 3'd0, 1'b0, 8'd10, 8'd10, 1'b0);
        read_expect("basic_ch1", 3'd1, 1'b0, 8'd30, 8'd30, 1'b0);
        read_expect("basic_ch2", 3'd2, 1'b0, 8'd0,  8'd0,  1'b0);
        cycle();
        chk("valid_pulse", w_rd_valid, 64'd0);

        // Wrap / saturate: preload ch2 and ch3 to 254, then +3, then +1.
        inc = 8'b1010_0000;
        cycles(127);
        inc = 8'b1111_0000;
        cycle();
        inc = 8'd0;
        read_expect("ovf_ch2", 3'd2, 1'b0, 8'd1, 8'd255, 1'b0);
        read_expect("ovf_ch3", 3'd3, 1'b0, 8'd1, 8'd255, 1'b0);
        chk("ovf2_w", w_ovf[2], 64'd1);
        chk("ovf3_s", s_ovf[3], 64'd1);
        chk("ovf_any_w", w_ovf_any, 64'd1);
        inc = 8'b0101_0000;
        cycle();
        inc = 8'd0;
        read_expect("after_ch2", 3'd2, 1'b0, 8'd2, 8'd255, 1'b0);
        chk("ovf_sticky_w", w_ovf, 64'b1100);
        chk("ovf_sticky_s", s_ovf, 64'b1100);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        read_expect("clear_ch2", 3'd2, 1'b0, 8'd0, 8'd0, 1'b0);
        chk("clear_ovf", w_ovf_any, 64'd0);

        // Snapshot + clear in the same cycle as an increment.
        inc = 8'b0000_0001;
        cycles(10);
        snap  = 1'b1;
        clear = 1'b1;
        cycle();
        inc   = 8'd0;
        snap  = 1'b0;
        clear = 1'b0;
        read_expect("shadow_ch0", 3'd0, 1'b1, 8'd10, 8'd10, 1'b0);
        read_expect("live_ch0",   3'd0, 1'b0, 8'd0,  8'd0,  1'b0);

        // Gating: freeze and global_en drop increments.
        inc = 8'b0000_1000;
        cycles(3);
        inc    = 8'hFF;
        freeze = 1'b1;
        cycles(5);
        freeze    = 1'b0;
        global_en = 1'b0;
        cycles(5);
        global_en = 1'b1;
        inc       = 8'd0;
        read_expect("gated_ch1", 3'd1, 1'b0, 8'd6, 8'd6, 1'b0);
        read_expect("oor_5",     3'd5, 1'b0, 8'd0, 8'd0, 1'b1);
        cycle();
        chk("err_idle", w_rd_err, 64'd0);

        // Randomised traffic against the model.
        for (int k = 0; k < 600; k++) begin
            inc       = 8'($urandom);
            global_en = ($urandom_range(7) != 0);
            freeze    = ($urandom_range(7) == 0);
            clear     = ($urandom_range(31) == 0);
            snap      = ($urandom_range(3) == 0);
            rd_en     = ($urandom_range(3) != 0);
            rd_addr   = 3'($urandom_range(7));
            rd_src    = 1'($urandom_range(1));
            cycle();
        end
        idle();

        // Reset during a pending read.
        inc = 8'b0000_0100;
        cycles(2);
        inc     = 8'd0;
        rd_en   = 1'b1;
        rd_addr = 3'd1;
        cycle();
        chk("pending_valid", w_rd_valid, 64'd1);
        rd_en = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_valid_w", w_rd_valid, 64'd0);
        chk("rst_valid_s", s_rd_valid, 64'd0);
        #1;
        reset = 1'b1;
        read_expect("rst_live1",   3'd1, 1'b0, 8'd0, 8'd0, 1'b0);
        read_expect("rst_shadow0", 3'd0, 1'b1, 8'd0, 8'd0, 1'b0);
        inc = 8'b0000_0001;
        cycle();
        inc = 8'd0;
        read_expect("resume_ch0", 3'd0, 1'b0, 8'd1, 8'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
